// File: rtl/add_and_or_unit_pkg.sv
// Shared op encodings and width constant for add_and_or_unit.
// Optional XOR on op 2'b11 is enabled by defining UNIT_XOR_EN.
package add_and_or_pkg;

   localparam int XLEN = 64;

   typedef logic [1:0] op_t;

   localparam op_t OP_AND = 2'b00;
   localparam op_t OP_OR  = 2'b01;
   localparam op_t OP_ADD = 2'b10;
   localparam op_t OP_XOR = 2'b11;

endpackage

// File: rtl/add_and_or_unit_if.sv
// Request/response bundle between the execute operand muxes and the unit.
// Master drives requests; slave returns registered result and flags.
interface add_and_or_unit_if #(
   parameter int WIDTH = 64
) ();
   import add_and_or_pkg::*;

   logic             in_valid;
   op_t              op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             out_valid;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic             carry;
   logic             overflow;

   modport master (
      output in_valid, op, a, b, cin,
      input  out_valid, result, zero, carry, overflow
   );

   modport slave (
      input  in_valid, op, a, b, cin,
      output out_valid, result, zero, carry, overflow
   );

endinterface

// File: rtl/add_and_or_unit_add_core.sv
// Combinational adder with carry-in, unsigned carry-out and signed overflow.
module add_core #(
   parameter int WIDTH = 64
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             carry,
   output logic             overflow
);

   logic [WIDTH:0] full;

   always_comb begin
      full     = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
      sum      = full[WIDTH-1:0];
      carry    = full[WIDTH];
      overflow = (a[WIDTH-1] == b[WIDTH-1]) &&
                 (full[WIDTH-1] != a[WIDTH-1]);
   end

endmodule

// File: rtl/add_and_or_unit.sv
// Registered ADD/AND/OR unit with zero, carry and overflow flags.
// Define UNIT_XOR_EN to map op 2'b11 to XOR instead of reserved.
module add_and_or_unit
   import add_and_or_pkg::*;
#(
   parameter int WIDTH = XLEN
) (
   input logic              clk,
   input logic              rst,
   add_and_or_unit_if.slave bus
);

   logic [WIDTH-1:0] add_sum;
   logic             add_carry;
   logic             add_ovf;
   logic [WIDTH-1:0] nxt_result;
   logic             nxt_carry;
   logic             nxt_ovf;

   add_core #(.WIDTH(WIDTH)) u_add (
      .a        (bus.a),
      .b        (bus.b),
      .cin      (bus.cin),
      .sum      (add_sum),
      .carry    (add_carry),
      .overflow (add_ovf)
   );

   always_comb begin
      nxt_result = '0;
      nxt_carry  = 1'b0;
      nxt_ovf    = 1'b0;
      unique case (bus.op)
         OP_AND: nxt_result = bus.a & bus.b;
         OP_OR:  nxt_result = bus.a | bus.b;
         OP_ADD: begin
            nxt_result = add_sum;
            nxt_carry  = add_carry;
            nxt_ovf    = add_ovf;
         end
`ifdef UNIT_XOR_EN
         OP_XOR: nxt_result = bus.a ^ bus.b;
`else
         default: nxt_result = '0;
`endif
      endcase
   end

   // Idle cycles drop out_valid but keep the last result and flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.out_valid <= 1'b0;
         bus.result    <= '0;
         bus.zero      <= 1'b0;
         bus.carry     <= 1'b0;
         bus.overflow  <= 1'b0;
      end else begin
         bus.out_valid <= bus.in_valid;
         if (bus.in_valid) begin
            bus.result   <= nxt_result;
            bus.zero     <= (nxt_result == '0);
            bus.carry    <= nxt_carry;
            bus.overflow <= nxt_ovf;
         end
      end
   end

endmodule

// File: tb/tb_add_and_or_unit.sv
// Self-checking bench for add_and_or_unit: directed cases plus random traffic.
module tb_add_and_or_unit;
   import add_and_or_pkg::*;

   localparam int W = 64;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;

   logic [W-1:0] e_result;
   logic         e_zero, e_carry, e_ovf, e_valid;

   always #5 clk = ~clk;

   add_and_or_unit_if #(.WIDTH(W)) bus ();

   add_and_or_unit #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic chk(input string tag, input logic [W-1:0] got,
                      input logic [W-1:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference model: arithmetic on wide signed/unsigned integers.
   task automatic model(input op_t op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic cin);
      logic [W:0]          u;
      logic signed [W+1:0] s, sa, sb, sc;
      e_carry = 1'b0;
      e_ovf   = 1'b0;
      case (op)
         OP_AND: e_result = a & b;
         OP_OR:  e_result = a | b;
         OP_ADD: begin
            u        = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
            e_result = u[W-1:0];
            e_carry  = u > {1'b0, {W{1'b1}}};
            sa       = $signed(a);
            sb       = $signed(b);
            sc       = $signed({{(W+1){1'b0}}, cin});
            s        = sa + sb + sc;
            e_ovf    = (s > $signed({2'b00, 1'b0, {(W-1){1'b1}}})) ||
                       (s < $signed({2'b11, 1'b1, {(W-1){1'b0}}}));
         end
         default: begin
`ifdef UNIT_XOR_EN
            e_result = a ^ b;
`else
            e_result = '0;
`endif
         end
      endcase
      e_zero = (e_result == 0);
   endtask

   task automatic step(input string tag, input logic r, input logic v,
                       input op_t op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic cin);
      @(negedge clk);
      rst          = r;
      bus.in_valid = v;
      bus.op       = op;
      bus.a        = a;
      bus.b        = b;
      bus.cin      = cin;
      if (r) begin
         e_result = '0;
         e_zero   = 1'b0;
         e_carry  = 1'b0;
         e_ovf    = 1'b0;
         e_valid  = 1'b0;
      end else begin
         e_valid = v;
         if (v) model(op, a, b, cin);
      end
      @(posedge clk);
      #1;
      chk({tag, ".valid"}, W'(bus.out_valid), W'(e_valid));
      chk({tag, ".result"}, bus.result, e_result);
      chk({tag, ".zero"}, W'(bus.zero), W'(e_zero));
      chk({tag, ".carry"}, W'(bus.carry), W'(e_carry));
      chk({tag, ".ovf"}, W'(bus.overflow), W'(e_ovf));
   endtask

   initial begin
      bus.in_valid = 1'b1;
      bus.op       = OP_ADD;
      bus.a        = 64'd1;
      bus.b        = 64'd2;
      bus.cin      = 1'b0;

      step("rst0", 1, 1, OP_ADD, 64'd1, 64'd2, 0);
      step("rst1", 1, 1, OP_OR, 64'hFF, 64'h1, 0);
      step("post_rst", 0, 0, OP_AND, 64'd0, 64'd0, 0);
      if (e_result !== 0 || bus.result !== 0)
         chk("rst_result", bus.result, 0);

      step("and", 0, 1, OP_AND, 64'hF0F0_0000_0000_00FF,
           64'h0FF0_0000_0000_0F0F, 1);
      chk("and.lit", bus.result, 64'h00F0_0000_0000_000F);
      step("or", 0, 1, OP_OR, 64'hF0F0_0000_0000_00FF,
           64'h0FF0_0000_0000_0F0F, 1);
      chk("or.lit", bus.result, 64'hFFF0_0000_0000_0FFF);
      step("add_wrap", 0, 1, OP_ADD, '1, 64'd1, 0);
      chk("add_wrap.c", W'(bus.carry), 1);
      step("add_ovp", 0, 1, OP_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 0);
      chk("add_ovp.lit", bus.result, 64'h8000_0000_0000_0000);
      chk("add_ovp.o", W'(bus.overflow), 1);
      step("add_ovn", 0, 1, OP_ADD, 64'h8000_0000_0000_0000,
           64'h8000_0000_0000_0000, 0);
      chk("add_ovn.z", W'(bus.zero), 1);
      step("add_cin", 0, 1, OP_ADD, 64'd5, 64'd7, 1);
      chk("add_cin.lit", bus.result, 64'd13);
      step("add_neg", 0, 1, OP_ADD, -64'sd3, 64'd3, 0);
      chk("add_neg.c", W'(bus.carry), 1);
      step("idle", 0, 0, OP_ADD, 64'd9, 64'd9, 1);
      chk("idle.lit", bus.result, 0);
      step("op11", 0, 1, OP_XOR, 64'hAAAA, 64'hFFFF, 1);
`ifdef UNIT_XOR_EN
      chk("op11.lit", bus.result, 64'h5555);
`else
      chk("op11.lit", bus.result, 0);
`endif
      step("mid_rst", 1, 1, OP_OR, 64'h1234, 64'h1, 0);
      step("after_mid", 0, 0, OP_OR, 64'h1234, 64'h1, 0);

      for (int i = 0; i < 300; i++) begin
         logic [W-1:0] ra, rb;
         logic [2:0]   sel;
         ra  = {$urandom, $urandom};
         rb  = {$urandom, $urandom};
         sel = 3'($urandom_range(0, 7));
         if (sel == 0) rb = ~ra;
         if (sel == 1) rb = -ra;
         if (sel == 2) ra = {1'b0, {(W-1){1'b1}}};
         step("rnd", ($urandom_range(0, 40) == 0), ($urandom_range(0, 3) != 0),
              op_t'($urandom_range(0, 3)), ra, rb, 1'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
